// File: rtl/fact_accel_if.sv
// Data-memory style bus between the datapath and the factorial accelerator.
//   we    master->slave  write enable (already address-decoded)
//   a     master->slave  word offset
//   wd    master->slave  write data
//   rd    slave->master  read data, combinational from a
//   busy  slave->master  accelerator is computing
interface fact_accel_if #(
    parameter int unsigned WIDTH = 32
);
    logic             we;
    logic [1:0]       a;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             busy;

    modport master (output we, a, wd, input rd, busy);
    modport slave  (input we, a, wd, output rd, busy);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: datapath writes N and GO, polls STATUS,
// then reads RESULT = N!. One multiply per cycle while in CALC.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  fact_accel_if slave: we/a/wd in, rd/busy out
//        offsets 0=N, 1=GO (reads busy), 2=STATUS {err,done}, 3=RESULT
module fact_accel #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NBITS = 4,
    parameter int unsigned MAX_N = 12
) (
    input  logic         clk,
    input  logic         rst,
    fact_accel_if.slave  bus
);

    localparam int unsigned PW = WIDTH + NBITS;
    localparam logic [NBITS-1:0] MAX_N_L = NBITS'(MAX_N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [NBITS-1:0] n, n_nxt;
    logic [NBITS-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] prod, prod_nxt;
    logic             done, done_nxt;
    logic             err, err_nxt;
    logic             start;
    logic [PW-1:0]    prod_full;

    // Full-width product; MAX_N bounds keep the upper bits zero on the legal path
    assign prod_full = {{NBITS{1'b0}}, prod} * {{WIDTH{1'b0}}, cnt};

    // State and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n     <= '0;
            cnt   <= '0;
            prod  <= WIDTH'(1);
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            cnt   <= cnt_nxt;
            prod  <= prod_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        cnt_nxt   = cnt;
        prod_nxt  = prod;
        done_nxt  = done;
        err_nxt   = err;
        start     = bus.we && (bus.a == 2'd1) && bus.wd[0] && (state != CALC);

        // N is frozen while a computation is in flight
        if (bus.we && (bus.a == 2'd0) && (state != CALC)) begin
            n_nxt = bus.wd[NBITS-1:0];
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    done_nxt = 1'b0;
                    err_nxt  = 1'b0;
                    if (n > MAX_N_L) begin
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        prod_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = n;
                        prod_nxt  = WIDTH'(1);
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt <= NBITS'(1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    prod_nxt = prod_full[WIDTH-1:0];
                    cnt_nxt  = cnt - NBITS'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state == CALC);

    // Same-cycle read mux, like a data memory
    always_comb begin
        bus.rd = '0;
        case (bus.a)
            2'd0: bus.rd = {{(WIDTH-NBITS){1'b0}}, n};
            2'd1: bus.rd = {{(WIDTH-1){1'b0}}, bus.busy};
            2'd2: bus.rd = {{(WIDTH-2){1'b0}}, err, done};
            default: bus.rd = err ? '0 : prod;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// Directed testbench for fact_accel with immediate-assertion checks.
module tb_fact_accel;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    fact_accel_if #(.WIDTH(32)) bus ();

    fact_accel #(.WIDTH(32), .NBITS(4), .MAX_N(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write one register; returns 1ns after the edge that samples it
    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.wd = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        bus.a = addr;
        #1;
        tests++;
        assert (bus.rd === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, bus.rd, exp);
        end
    endtask

    task automatic chk_busy(input logic exp, input string tag);
        tests++;
        assert (bus.busy === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, bus.busy, exp);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        bus.we = 1'b0;
        bus.a  = 2'd0;
        bus.wd = '0;
        tick(3);

        // Reset values
        chk_busy(1'b0, "rst_busy");
        chk(2'd0, 32'd0, "rst_n");
        chk(2'd2, 32'd0, "rst_status");
        chk(2'd3, 32'd1, "rst_result");
        @(negedge clk);
        rst = 1'b0;

        // 5! : busy for 5 edges
        wr(2'd0, 32'd5);
        chk(2'd0, 32'd5, "n5_readback");
        wr(2'd1, 32'd1);
        chk_busy(1'b1, "n5_busy_start");
        chk(2'd1, 32'd1, "n5_go_reads_busy");
        chk(2'd2, 32'd0, "n5_status_early");
        tick(4);
        chk_busy(1'b1, "n5_busy_edge4");
        chk(2'd2, 32'd0, "n5_status_edge4");
        tick(1);
        chk_busy(1'b0, "n5_busy_done");
        chk(2'd2, 32'd1, "n5_status");
        chk(2'd3, 32'd120, "n5_result");

        // 0! and 1! complete after one edge
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd1);
        chk_busy(1'b1, "n0_busy");
        tick(1);
        chk(2'd2, 32'd1, "n0_status");
        chk(2'd3, 32'd1, "n0_result");
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd1);
        chk(2'd2, 32'd0, "n1_status_early");
        tick(1);
        chk(2'd2, 32'd1, "n1_status");
        chk(2'd3, 32'd1, "n1_result");

        // 12! is the largest legal operand
        wr(2'd0, 32'd12);
        wr(2'd1, 32'd1);
        tick(11);
        chk_busy(1'b1, "n12_busy_edge11");
        chk(2'd2, 32'd0, "n12_status_edge11");
        tick(1);
        chk(2'd2, 32'd1, "n12_status");
        chk(2'd3, 32'h1C8CFC00, "n12_result");

        // 13 is an error, reported right after the start edge
        wr(2'd0, 32'd13);
        wr(2'd1, 32'd1);
        chk_busy(1'b0, "n13_busy");
        chk(2'd2, 32'd3, "n13_status");
        chk(2'd3, 32'd0, "n13_result");

        // Restart from DONE clears the error
        wr(2'd0, 32'd4);
        wr(2'd1, 32'd1);
        chk(2'd2, 32'd0, "n4_status_clear");
        tick(4);
        chk(2'd2, 32'd1, "n4_status");
        chk(2'd3, 32'd24, "n4_result");

        // GO with wd[0]=0 and writes to STATUS/RESULT do nothing
        wr(2'd1, 32'd0);
        chk_busy(1'b0, "go0_busy");
        chk(2'd2, 32'd1, "go0_status");
        wr(2'd3, 32'hDEAD_BEEF);
        wr(2'd2, 32'h0000_0000);
        chk(2'd3, 32'd24, "wr_result_ignored");
        chk(2'd2, 32'd1, "wr_status_ignored");

        // N and GO writes during CALC are ignored
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        tick(3);
        chk_busy(1'b1, "n6_busy_edge5");
        chk(2'd0, 32'd6, "n6_readback");
        tick(1);
        chk(2'd2, 32'd1, "n6_status");
        chk(2'd3, 32'd720, "n6_result");

        // Reset mid-CALC aborts everything
        wr(2'd0, 32'd7);
        wr(2'd1, 32'd1);
        tick(2);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        chk_busy(1'b0, "midrst_busy");
        chk(2'd2, 32'd0, "midrst_status");
        chk(2'd0, 32'd0, "midrst_n");
        chk(2'd3, 32'd1, "midrst_result");
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        chk(2'd2, 32'd0, "post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
